// File: rtl/dec_seq.sv
// dec_seq: binary code to one-hot/thermometer decoder with registered output stage and self-sweep
module dec_seq #(
  parameter int IN_W = 8,
  localparam int OUT_W = 2 ** IN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_code,
  input  logic             in_therm,
  input  logic             sweep_start,
  output logic             sweep_busy,
  output logic             sweep_done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_vec,
  output logic [IN_W-1:0]  out_code
);
  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;
  state_t state, state_nx;
  logic [IN_W-1:0] cnt;
  logic sweep_therm;
  logic can_load, ext_load, sweep_load, load, load_therm;
  logic [IN_W-1:0] load_code;
  logic [OUT_W-1:0] dec;
  // Handshake, load source selection and next-state; sweep_start wins over an external code
  always_comb begin
    can_load = !out_valid || out_ready;
    in_ready = rst_n && state == IDLE && can_load && !sweep_start;
    ext_load = in_valid && in_ready;
    sweep_load = state == SWEEP && can_load;
    load = ext_load || sweep_load;
    load_code = sweep_load ? cnt : in_code;
    load_therm = sweep_load ? sweep_therm : in_therm;
    sweep_busy = state == SWEEP;
    sweep_done = state == DONE;
    state_nx = state == IDLE ? (sweep_start ? SWEEP : IDLE) :
               state == SWEEP ? ((sweep_load && &cnt) ? DONE : SWEEP) : IDLE;
  end
  for (genvar g = 0; g < OUT_W; g++) begin : g_dec
    assign dec[g] = load_therm ? (load_code >= IN_W'(g)) : (load_code == IN_W'(g));
  end
  // State, sweep counter (stalls under back-pressure, never wraps) and output register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      sweep_therm <= 1'b0;
      out_valid <= 1'b0;
      out_vec <= '0;
      out_code <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && sweep_start) begin
        cnt <= '0;
        sweep_therm <= in_therm;
      end else if (sweep_load && !(&cnt)) begin
        cnt <= cnt + 1'b1;
      end
      out_valid <= load || (out_valid && !out_ready);
      if (load) begin
        out_vec <= dec;
        out_code <= load_code;
      end
    end
  end
endmodule

// File: tb/tb_dec_seq.sv
// tb_dec_seq: vector table, directed sweep/reset sequences and random scoreboard for dec_seq
module tb_dec_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, in_therm = 1'b0, sweep_start = 1'b0, out_ready = 1'b0;
  logic [2:0] in_code = 3'd0;
  logic in_ready, sweep_busy, sweep_done, out_valid;
  logic [7:0] out_vec;
  logic [2:0] out_code;
  logic sweep_start8 = 1'b0;
  logic in_ready8, sweep_busy8, sweep_done8, out_valid8;
  logic [255:0] out_vec8;
  logic [7:0] out_code8;
  int checks = 0, errors = 0;

  dec_seq #(.IN_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .in_therm(in_therm), .sweep_start(sweep_start), .sweep_busy(sweep_busy), .sweep_done(sweep_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec), .out_code(out_code)
  );

  dec_seq #(.IN_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(1'b0), .in_ready(in_ready8), .in_code(8'd0),
    .in_therm(1'b0), .sweep_start(sweep_start8), .sweep_busy(sweep_busy8), .sweep_done(sweep_done8),
    .out_valid(out_valid8), .out_ready(1'b1), .out_vec(out_vec8), .out_code(out_code8)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0] code;
    logic       therm;
    logic [7:0] vec;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] dec_model(input int c, input bit t);
    return t ? ((256'(1) << (c + 1)) - 256'(1)) : (256'(1) << c);
  endfunction

  task automatic run_sweep(input bit therm, input bit toggle);
    int idx = 0, done_cnt = 0;
    bit done_seen = 0;
    in_valid = 1'b1;
    in_code = 3'd6;
    in_therm = therm;
    sweep_start = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("sweep_prio_ready", 256'(in_ready), 256'(0));
    step;
    sweep_start = 1'b0;
    in_therm = ~therm;
    for (int cyc = 0; cyc < 200 && !(done_seen && idx == 8); cyc++) begin
      out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      sweep_start = toggle && !done_seen && (cyc % 3 == 0);
      in_valid = !done_seen;
      @(negedge clk);
      chk("sweep_busy", 256'(sweep_busy), 256'(!(done_seen || sweep_done)));
      if (!done_seen) chk("sweep_in_ready", 256'(in_ready), 256'(0));
      if (sweep_done) begin
        done_cnt++;
        done_seen = 1;
      end
      if (out_valid && out_ready) begin
        chk("sweep_code", 256'(out_code), 256'(idx));
        chk("sweep_vec", 256'(out_vec), dec_model(idx, therm));
        idx++;
      end
      step;
    end
    chk("sweep_done_count", 256'(done_cnt), 256'(1));
    chk("sweep_result_count", 256'(idx), 256'(8));
    in_valid = 1'b0;
    sweep_start = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("sweep_drained", 256'(out_valid), 256'(0));
    step;
  endtask

  initial begin
    logic [255:0] qv[$];
    int qc[$];
    logic [7:0] hold_vec;
    bit held, found;
    int idx, pulses;
    tbl[0] = '{3'd5, 1'b0, 8'h20};
    tbl[1] = '{3'd2, 1'b1, 8'h07};
    tbl[2] = '{3'd7, 1'b1, 8'hFF};
    tbl[3] = '{3'd0, 1'b1, 8'h01};
    tbl[4] = '{3'd0, 1'b0, 8'h01};
    tbl[5] = '{3'd7, 1'b0, 8'h80};
    tbl[6] = '{3'd3, 1'b1, 8'h0F};
    step;
    step;
    @(negedge clk);
    chk("rst_out_valid", 256'(out_valid), 256'(0));
    chk("rst_out_vec", 256'(out_vec), 256'(0));
    chk("rst_out_code", 256'(out_code), 256'(0));
    chk("rst_busy", 256'(sweep_busy), 256'(0));
    chk("rst_done", 256'(sweep_done), 256'(0));
    chk("rst_in_ready", 256'(in_ready), 256'(0));
    chk("rst_out_valid8", 256'(out_valid8), 256'(0));
    step;
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_code = tbl[i].code;
      in_therm = tbl[i].therm;
      out_ready = 1'b1;
      @(negedge clk);
      chk("tbl_in_ready", 256'(in_ready), 256'(1));
      step;
      in_valid = 1'b0;
      @(negedge clk);
      chk("tbl_out_valid", 256'(out_valid), 256'(1));
      chk("tbl_out_vec", 256'(out_vec), 256'(tbl[i].vec));
      chk("tbl_out_code", 256'(out_code), 256'(tbl[i].code));
      step;
    end
    in_valid = 1'b1;
    in_code = 3'd3;
    in_therm = 1'b0;
    out_ready = 1'b1;
    step;
    in_code = 3'd5;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 256'(out_valid), 256'(1));
      chk("bp_out_vec", 256'(out_vec), 256'(8'h08));
      chk("bp_out_code", 256'(out_code), 256'(3));
      chk("bp_in_ready", 256'(in_ready), 256'(0));
      step;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 256'(in_ready), 256'(1));
    step;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_next_code", 256'(out_code), 256'(5));
    chk("bp_next_vec", 256'(out_vec), 256'(8'h20));
    step;
    held = 0;
    hold_vec = '0;
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_code = 3'($urandom_range(0, 7));
      in_therm = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      chk("rnd_out_valid", 256'(out_valid), 256'(qc.size() != 0));
      chk("rnd_in_ready", 256'(in_ready), 256'(qc.size() == 0 || out_ready));
      if (held) chk("rnd_hold", 256'(out_vec), 256'(hold_vec));
      if (out_valid && out_ready && qc.size() != 0) begin
        chk("rnd_code", 256'(out_code), 256'(qc[0]));
        chk("rnd_vec", 256'(out_vec), qv[0]);
        void'(qc.pop_front());
        void'(qv.pop_front());
      end
      if (in_valid && in_ready) begin
        qv.push_back(dec_model(int'(in_code), in_therm));
        qc.push_back(int'(in_code));
      end
      held = out_valid && !out_ready;
      hold_vec = out_vec;
      step;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step;
    step;
    run_sweep(1'b0, 1'b0);
    run_sweep(1'b0, 1'b1);
    run_sweep(1'b1, 1'b1);
    in_therm = 1'b0;
    sweep_start = 1'b1;
    out_ready = 1'b1;
    step;
    sweep_start = 1'b0;
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (out_valid && out_code == 3'd4) found = 1;
      step;
    end
    chk("rst_sweep_found4", 256'(found), 256'(1));
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_sweep_in_ready", 256'(in_ready), 256'(0));
    step;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_sweep_valid", 256'(out_valid), 256'(0));
    chk("rst_sweep_vec", 256'(out_vec), 256'(0));
    chk("rst_sweep_code", 256'(out_code), 256'(0));
    chk("rst_sweep_busy", 256'(sweep_busy), 256'(0));
    chk("rst_sweep_done", 256'(sweep_done), 256'(0));
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sweep_done || sweep_busy) pulses++;
      step;
    end
    chk("rst_sweep_no_done", 256'(pulses), 256'(0));
    sweep_start8 = 1'b1;
    step;
    sweep_start8 = 1'b0;
    idx = 0;
    for (int cyc = 0; cyc < 600 && idx < 256; cyc++) begin
      @(negedge clk);
      if (out_valid8) begin
        chk("w8_vec", out_vec8, 256'(1) << idx);
        chk("w8_code", 256'(out_code8), 256'(idx));
        idx++;
      end
      step;
    end
    chk("w8_count", 256'(idx), 256'(256));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
